// File: rtl/cbus_rr_arbiter_if.sv
// cbus arbitration bundle: per-requester request/response lanes on the cache
// side plus the single shared request/response pair towards the memory bus.
interface cbus_rr_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LW         = 8
);
  // requester side: one lane per input
  logic [NUM_INPUTS-1:0] ireqs_valid;
  logic [NUM_INPUTS-1:0] ireqs_is_write;
  logic [2:0]            ireqs_size   [NUM_INPUTS];
  logic [AW-1:0]         ireqs_addr   [NUM_INPUTS];
  logic [DW/8-1:0]       ireqs_strobe [NUM_INPUTS];
  logic [DW-1:0]         ireqs_data   [NUM_INPUTS];
  logic [LW-1:0]         ireqs_len    [NUM_INPUTS];

  logic [NUM_INPUTS-1:0] iresps_ready;
  logic [NUM_INPUTS-1:0] iresps_last;
  logic [DW-1:0]         iresps_data  [NUM_INPUTS];

  // memory side: single shared port
  logic                  oreq_valid;
  logic                  oreq_is_write;
  logic [2:0]            oreq_size;
  logic [AW-1:0]         oreq_addr;
  logic [DW/8-1:0]       oreq_strobe;
  logic [DW-1:0]         oreq_data;
  logic [LW-1:0]         oreq_len;

  logic                  oresp_ready;
  logic                  oresp_last;
  logic [DW-1:0]         oresp_data;

  // arbiter view
  modport slave (
    input  ireqs_valid, ireqs_is_write, ireqs_size, ireqs_addr,
           ireqs_strobe, ireqs_data, ireqs_len,
    output iresps_ready, iresps_last, iresps_data,
    output oreq_valid, oreq_is_write, oreq_size, oreq_addr,
           oreq_strobe, oreq_data, oreq_len,
    input  oresp_ready, oresp_last, oresp_data
  );

  // environment view: requesters plus memory bus
  modport master (
    output ireqs_valid, ireqs_is_write, ireqs_size, ireqs_addr,
           ireqs_strobe, ireqs_data, ireqs_len,
    input  iresps_ready, iresps_last, iresps_data,
    input  oreq_valid, oreq_is_write, oreq_size, oreq_addr,
           oreq_strobe, oreq_data, oreq_len,
    output oresp_ready, oresp_last, oresp_data
  );
endinterface

// File: rtl/cbus_rr_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one cbus memory port among
// NUM_INPUTS cache-side requesters. A grant is held for a whole burst and is
// followed by one mandatory IDLE cycle before the next grant.
module cbus_rr_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int ROUND_ROBIN = 1,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int LW          = 8,
  localparam int GW         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cbus_rr_arbiter_if.slave       cbus,
  output logic                   busy_o,
  output logic [GW-1:0]          grant_idx_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic            busy_q;
  logic [GW-1:0]   grant_idx_q;
  logic [GW-1:0]   ptr_q;

  logic            hit_d;
  logic [GW-1:0]   winner_d;
  logic            burst_done;

  assign burst_done = cbus.oresp_ready && cbus.oresp_last;

  // Search starts just after the last served input (or at 0 for fixed priority);
  // the first valid input found in that circular order wins.
  always_comb begin
    int start;
    int idx;
    logic [GW-1:0] cand;
    hit_d    = 1'b0;
    winner_d = '0;
    start    = (ROUND_ROBIN != 0) ? ((int'(ptr_q) + 1) % NUM_INPUTS) : 0;
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx  = (start + k) % NUM_INPUTS;
      cand = GW'(idx);
      if (!hit_d && cbus.ireqs_valid[cand]) begin
        hit_d    = 1'b1;
        winner_d = cand;
      end
    end
  end

  // Grant FSM: latch a winner in IDLE, hold it until the last accepted beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      grant_idx_q <= '0;
      ptr_q       <= GW'(NUM_INPUTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_d) begin
            grant_idx_q <= winner_d;
            state_q     <= BUSY;
            busy_q      <= 1'b1;
          end
        end
        BUSY: begin
          // last without ready is not a completed beat
          if (burst_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (ROUND_ROBIN != 0) begin
              ptr_q <= grant_idx_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Forward the granted request unchanged while busy; the bus sees zeros in IDLE.
  always_comb begin
    cbus.oreq_valid    = 1'b0;
    cbus.oreq_is_write = 1'b0;
    cbus.oreq_size     = '0;
    cbus.oreq_addr     = '0;
    cbus.oreq_strobe   = '0;
    cbus.oreq_data     = '0;
    cbus.oreq_len      = '0;
    if (busy_q) begin
      cbus.oreq_valid    = cbus.ireqs_valid[grant_idx_q];
      cbus.oreq_is_write = cbus.ireqs_is_write[grant_idx_q];
      cbus.oreq_size     = cbus.ireqs_size[grant_idx_q];
      cbus.oreq_addr     = cbus.ireqs_addr[grant_idx_q];
      cbus.oreq_strobe   = cbus.ireqs_strobe[grant_idx_q];
      cbus.oreq_data     = cbus.ireqs_data[grant_idx_q];
      cbus.oreq_len      = cbus.ireqs_len[grant_idx_q];
    end
  end

  // Route the memory response only to the granted input; everyone else sees zeros.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_resp
    logic sel;
    assign sel                  = busy_q && (grant_idx_q == GW'(gi));
    assign cbus.iresps_ready[gi] = sel & cbus.oresp_ready;
    assign cbus.iresps_last[gi]  = sel & cbus.oresp_last;
    assign cbus.iresps_data[gi]  = sel ? cbus.oresp_data : '0;
  end

  assign busy_o      = busy_q;
  assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed self-checking bench for cbus_rr_arbiter: one round-robin instance
// and one fixed-priority instance driven from a single sequence of tasks.
module tb_cbus_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cbus_rr_arbiter_if #(.NUM_INPUTS(N), .AW(AW), .DW(DW), .LW(LW)) rr_if ();
  cbus_rr_arbiter_if #(.NUM_INPUTS(N), .AW(AW), .DW(DW), .LW(LW)) fp_if ();

  logic          rr_busy, fp_busy;
  logic [GW-1:0] rr_grant, fp_grant;

  cbus_rr_arbiter #(.NUM_INPUTS(N), .ROUND_ROBIN(1), .AW(AW), .DW(DW), .LW(LW)) u_rr (
    .clk_i(clk), .rst_i(rst), .cbus(rr_if), .busy_o(rr_busy), .grant_idx_o(rr_grant)
  );

  cbus_rr_arbiter #(.NUM_INPUTS(N), .ROUND_ROBIN(0), .AW(AW), .DW(DW), .LW(LW)) u_fp (
    .clk_i(clk), .rst_i(rst), .cbus(fp_if), .busy_o(fp_busy), .grant_idx_o(fp_grant)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      rr_if.ireqs_valid[i] = 1'b0; rr_if.ireqs_is_write[i] = 1'b0;
      rr_if.ireqs_size[i] = '0; rr_if.ireqs_addr[i] = '0;
      rr_if.ireqs_strobe[i] = '0; rr_if.ireqs_data[i] = '0; rr_if.ireqs_len[i] = '0;
      fp_if.ireqs_valid[i] = 1'b0; fp_if.ireqs_is_write[i] = 1'b0;
      fp_if.ireqs_size[i] = '0; fp_if.ireqs_addr[i] = '0;
      fp_if.ireqs_strobe[i] = '0; fp_if.ireqs_data[i] = '0; fp_if.ireqs_len[i] = '0;
    end
    rr_if.oresp_ready = 1'b0; rr_if.oresp_last = 1'b0; rr_if.oresp_data = '0;
    fp_if.oresp_ready = 1'b0; fp_if.oresp_last = 1'b0; fp_if.oresp_data = '0;
  endtask

  task automatic set_req(input int i, input logic [LW-1:0] len);
    rr_if.ireqs_valid[i]    = 1'b1;
    rr_if.ireqs_is_write[i] = 1'(i & 1);
    rr_if.ireqs_size[i]     = 3'd2;
    rr_if.ireqs_addr[i]     = addr_of(i);
    rr_if.ireqs_strobe[i]   = 4'hF;
    rr_if.ireqs_data[i]     = 32'hD000_0000 + 32'(i);
    rr_if.ireqs_len[i]      = len;
  endtask

  task automatic set_fp_req(input int i);
    fp_if.ireqs_valid[i] = 1'b1;
    fp_if.ireqs_addr[i]  = addr_of(i);
    fp_if.ireqs_len[i]   = '0;
  endtask

  // Hold reset for two cycles, release it just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    rr_if.oresp_ready = 1'b1; rr_if.oresp_last = 1'b1; rr_if.oresp_data = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", rr_busy); end
    total++; if (rr_grant !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", rr_grant); end
    total++; if (rr_if.oreq_valid !== 1'b0) begin bad++; $display("FAIL reset_oreq_valid: got %b want 0", rr_if.oreq_valid); end
    total++; if (rr_if.iresps_ready !== 4'b0 || rr_if.iresps_last !== 4'b0) begin bad++; $display("FAIL reset_iresps: ready=%b last=%b want 0000", rr_if.iresps_ready, rr_if.iresps_last); end
    for (int i = 0; i < N; i++) begin
      total++; if (rr_if.iresps_data[i] !== 32'h0) begin bad++; $display("FAIL reset_iresp_data%0d: got %h want 0", i, rr_if.iresps_data[i]); end
    end
    clear_inputs();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 8'd3);
    #1;
    total++; if (rr_busy !== 1'b0 || rr_if.oreq_valid !== 1'b0) begin bad++; $display("FAIL single_latency: busy=%b oreq_valid=%b want 0 0", rr_busy, rr_if.oreq_valid); end
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      rr_if.oresp_ready = 1'b1;
      rr_if.oresp_last  = (b == 3);
      rr_if.oresp_data  = 32'hBEEF_0000 + 32'(b);
      #1;
      total++; if (rr_busy !== 1'b1 || rr_grant !== 2'd2) begin bad++; $display("FAIL single_grant beat%0d: busy=%b grant=%0d want 1 2", b, rr_busy, rr_grant); end
      total++; if (rr_if.oreq_valid !== 1'b1 || rr_if.oreq_addr !== addr_of(2) || rr_if.oreq_len !== 8'd3 || rr_if.oreq_data !== 32'hD000_0002 || rr_if.oreq_is_write !== 1'b0 || rr_if.oreq_strobe !== 4'hF || rr_if.oreq_size !== 3'd2)
        begin bad++; $display("FAIL single_oreq beat%0d: valid=%b addr=%h len=%0d data=%h", b, rr_if.oreq_valid, rr_if.oreq_addr, rr_if.oreq_len, rr_if.oreq_data); end
      total++; if (rr_if.iresps_ready !== 4'b0100 || rr_if.iresps_last !== ((b == 3) ? 4'b0100 : 4'b0000) || rr_if.iresps_data[2] !== 32'hBEEF_0000 + 32'(b))
        begin bad++; $display("FAIL single_iresp beat%0d: ready=%b last=%b data=%h", b, rr_if.iresps_ready, rr_if.iresps_last, rr_if.iresps_data[2]); end
    end
    @(posedge clk); #1;
    rr_if.ireqs_valid[2] = 1'b0; rr_if.oresp_ready = 1'b0; rr_if.oresp_last = 1'b0;
    #1;
    total++; if (rr_busy !== 1'b0 || rr_if.oreq_valid !== 1'b0) begin bad++; $display("FAIL single_release: busy=%b oreq_valid=%b want 0 0", rr_busy, rr_if.oreq_valid); end
    $display("test_single done");
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'd3);
    rr_if.oresp_ready = 1'b1;
    rr_if.oresp_data  = 32'h5555_AAAA;
    for (int g = 0; g < 5; g++) begin
      rr_if.oresp_last = 1'b0;
      #1;
      total++; if (rr_busy !== 1'b0 || rr_if.iresps_ready !== 4'b0 || rr_if.oreq_valid !== 1'b0)
        begin bad++; $display("FAIL rot_idle g%0d: busy=%b iresps_ready=%b oreq_valid=%b want 0", g, rr_busy, rr_if.iresps_ready, rr_if.oreq_valid); end
      for (int b = 0; b < 4; b++) begin
        @(posedge clk); #1;
        rr_if.oresp_last = (b == 3);
        #1;
        total++; if (rr_busy !== 1'b1 || rr_grant !== GW'(order[g]) || rr_if.iresps_ready !== onehot(order[g]) || rr_if.oreq_addr !== addr_of(order[g]))
          begin bad++; $display("FAIL rot_grant g%0d beat%0d: busy=%b grant=%0d ready=%b addr=%h want grant %0d", g, b, rr_busy, rr_grant, rr_if.iresps_ready, rr_if.oreq_addr, order[g]); end
      end
      @(posedge clk); #1;
      $display("rotation burst %0d granted input %0d", g, order[g]);
    end
    clear_inputs();
    $display("test_rotation done");
  endtask

  task automatic test_no_preempt();
    do_reset();
    set_req(3, 8'd3);
    rr_if.oresp_ready = 1'b1;
    rr_if.oresp_data  = 32'h1234_5678;
    #1;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      if (b == 1) set_req(0, 8'd0);
      rr_if.oresp_last = (b == 3);
      #1;
      total++; if (rr_busy !== 1'b1 || rr_grant !== 2'd3 || rr_if.iresps_ready[3] !== 1'b1)
        begin bad++; $display("FAIL nopre_hold beat%0d: busy=%b grant=%0d ready3=%b want 1 3 1", b, rr_busy, rr_grant, rr_if.iresps_ready[3]); end
      total++; if (rr_if.iresps_ready[0] !== 1'b0 || rr_if.iresps_last[0] !== 1'b0 || rr_if.iresps_data[0] !== 32'h0)
        begin bad++; $display("FAIL nopre_in0 beat%0d: ready=%b last=%b data=%h want 0", b, rr_if.iresps_ready[0], rr_if.iresps_last[0], rr_if.iresps_data[0]); end
    end
    // input 3 keeps requesting; input 0 must win the next arbitration
    @(posedge clk); #1;
    rr_if.oresp_last = 1'b0;
    #1;
    total++; if (rr_busy !== 1'b0 || rr_if.iresps_ready !== 4'b0) begin bad++; $display("FAIL nopre_gap: busy=%b ready=%b want 0", rr_busy, rr_if.iresps_ready); end
    @(posedge clk); #1;
    rr_if.oresp_last = 1'b1;
    #1;
    total++; if (rr_busy !== 1'b1 || rr_grant !== 2'd0 || rr_if.iresps_last !== 4'b0001)
      begin bad++; $display("FAIL nopre_next: busy=%b grant=%0d last=%b want 1 0 0001", rr_busy, rr_grant, rr_if.iresps_last); end
    @(posedge clk); #1;
    rr_if.ireqs_valid[0] = 1'b0;
    rr_if.oresp_last = 1'b0;
    #1;
    total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL nopre_gap2: busy=%b want 0", rr_busy); end
    @(posedge clk); #1;
    rr_if.oresp_last = 1'b1;
    #1;
    total++; if (rr_busy !== 1'b1 || rr_grant !== 2'd3) begin bad++; $display("FAIL nopre_rereq: busy=%b grant=%0d want 1 3", rr_busy, rr_grant); end
    @(posedge clk); #1;
    clear_inputs();
    $display("test_no_preempt done");
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_fp_req(1);
    set_fp_req(3);
    #1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      fp_if.oresp_ready = 1'b1; fp_if.oresp_last = 1'b1;
      #1;
      total++; if (fp_busy !== 1'b1 || fp_grant !== 2'd1 || fp_if.iresps_ready !== 4'b0010)
        begin bad++; $display("FAIL fixed_grant r%0d: busy=%b grant=%0d ready=%b want 1 1 0010", r, fp_busy, fp_grant, fp_if.iresps_ready); end
      @(posedge clk); #1;
      fp_if.oresp_ready = 1'b0; fp_if.oresp_last = 1'b0;
      #1;
      total++; if (fp_busy !== 1'b0) begin bad++; $display("FAIL fixed_gap r%0d: busy=%b want 0", r, fp_busy); end
    end
    fp_if.ireqs_valid[1] = 1'b0;
    @(posedge clk); #1;
    fp_if.oresp_ready = 1'b1; fp_if.oresp_last = 1'b1;
    #1;
    total++; if (fp_busy !== 1'b1 || fp_grant !== 2'd3 || fp_if.oreq_addr !== addr_of(3))
      begin bad++; $display("FAIL fixed_in3: busy=%b grant=%0d addr=%h want 1 3", fp_busy, fp_grant, fp_if.oreq_addr); end
    @(posedge clk); #1;
    clear_inputs();
    $display("test_fixed_priority done");
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(1, 8'd3);
    rr_if.oresp_ready = 1'b1; rr_if.oresp_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rr_busy !== 1'b1 || rr_grant !== 2'd1 || rr_if.oreq_valid !== 1'b1)
      begin bad++; $display("FAIL areset_pre: busy=%b grant=%0d valid=%b want 1 1 1", rr_busy, rr_grant, rr_if.oreq_valid); end
    #1 rst = 1'b1;
    #1;
    total++; if (rr_if.oreq_valid !== 1'b0 || rr_busy !== 1'b0 || rr_grant !== 2'd0 || rr_if.iresps_ready !== 4'b0)
      begin bad++; $display("FAIL areset_now: valid=%b busy=%b grant=%0d ready=%b want 0 0 0 0000", rr_if.oreq_valid, rr_busy, rr_grant, rr_if.iresps_ready); end
    set_req(0, 8'd3);
    rr_if.oresp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL areset_idle: busy=%b want 0", rr_busy); end
    @(posedge clk); #1;
    total++; if (rr_busy !== 1'b1 || rr_grant !== 2'd0) begin bad++; $display("FAIL areset_winner: busy=%b grant=%0d want 1 0", rr_busy, rr_grant); end
    clear_inputs();
    $display("test_async_reset done");
  endtask

  task automatic test_last_no_ready();
    do_reset();
    set_req(1, 8'd0);
    #1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      rr_if.oresp_ready = 1'b0; rr_if.oresp_last = 1'b1;
      #1;
      total++; if (rr_busy !== 1'b1 || rr_if.iresps_ready[1] !== 1'b0 || rr_if.iresps_last[1] !== 1'b1)
        begin bad++; $display("FAIL lnr_wait c%0d: busy=%b ready1=%b last1=%b want 1 0 1", c, rr_busy, rr_if.iresps_ready[1], rr_if.iresps_last[1]); end
    end
    @(posedge clk); #1;
    rr_if.oresp_ready = 1'b1;
    #1;
    total++; if (rr_busy !== 1'b1 || rr_if.iresps_ready !== 4'b0010) begin bad++; $display("FAIL lnr_ready: busy=%b ready=%b want 1 0010", rr_busy, rr_if.iresps_ready); end
    @(posedge clk); #1;
    rr_if.ireqs_valid[1] = 1'b0;
    #1;
    total++; if (rr_busy !== 1'b0 || rr_if.iresps_ready !== 4'b0 || rr_if.iresps_last !== 4'b0)
      begin bad++; $display("FAIL lnr_idle: busy=%b ready=%b last=%b want 0", rr_busy, rr_if.iresps_ready, rr_if.iresps_last); end
    @(posedge clk); #1;
    total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL lnr_stay_idle: busy=%b want 0", rr_busy); end
    clear_inputs();
    $display("test_last_no_ready done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_rotation();
    test_no_preempt();
    test_fixed_priority();
    test_async_reset();
    test_last_no_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
